uart_recv: RTL and testbench

- UART serial receiver: the downstream counterpart of the board's UART transmitter.
- Deserialises an 8N1 frame on rx_line into a parallel byte with a one-cycle done strobe.
- Runs on the 50 MHz system clock; the bit rate is selected at runtime by the same 3-bit baud code the transmitter uses.
- Uses 16x oversampling with mid-bit 3-sample majority voting for noise tolerance.

---
 rtl/uart_recv.sv | 210 +++++++++++++++++++++
 tb/tb_uart_recv.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_recv.sv
// uart_recv: 16x-oversampled 8N1 UART receiver with mid-bit 3-sample majority
// voting and a runtime-selectable baud code.
// Optional build macro UART_RECV_PARITY_EN adds an even-parity bit after data
// bit 7 and a parity_err output.
module uart_recv #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk_50mhz,
   input  logic       rst,
   input  logic [2:0] baud,
   input  logic       rx_line,
   output logic [7:0] rx_data,
   output logic       rx_done,
   output logic       rx_state,
`ifdef UART_RECV_PARITY_EN
   output logic       parity_err,
`endif
   output logic       frame_err
);

`ifdef UART_RECV_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   // Divider terminal count for a baud code; the counter runs 0..N inclusive.
   function automatic logic [12:0] term_of(input logic [2:0] code);
      case (code)
         3'd1:    term_of = 13'd162;
         3'd2:    term_of = 13'd80;
         3'd3:    term_of = 13'd53;
         3'd4:    term_of = 13'd26;
         default: term_of = 13'd325;
      endcase
   endfunction

   // Two-out-of-three vote over the mid-bit samples.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      maj3 = (a & b) | (a & c) | (b & c);
   endfunction

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rx_s;
   logic                   rx_s_prev;
   logic                   fall;
   logic [12:0]            term_q;
   logic [12:0]            div_cnt;
   logic                   sub_tick;
   logic [3:0]             sub_cnt;
   logic [1:0]             samp_q;
   logic [2:0]             bit_idx;
   logic [7:0]             shift_q;
   logic                   mid_tick;
   logic                   bit_end;
   logic                   vote;
   logic                   done_d;
   logic                   ferr_d;
   state_t                 state_q;
   state_t                 state_d;
`ifdef UART_RECV_PARITY_EN
   logic                   par_q;
   logic                   perr_d;
`endif

   assign rx_s     = sync_q[SYNC_STAGES-1];
   assign fall     = rx_s_prev & ~rx_s;
   assign sub_tick = (state_q != IDLE) && (div_cnt == term_q);
   assign mid_tick = sub_tick && (sub_cnt == 4'd9);
   assign bit_end  = sub_tick && (sub_cnt == 4'd15);
   assign vote     = maj3(samp_q[0], samp_q[1], rx_s);

   // Metastability synchroniser and edge-detect history; idles high.
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         sync_q    <= '1;
         rx_s_prev <= 1'b1;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], rx_line};
         rx_s_prev <= rx_s;
      end
   end

   // Baud capture on start edge, sub-tick divider and 16x sub-counter.
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         term_q  <= '0;
         div_cnt <= '0;
         sub_cnt <= '0;
      end else begin
         if (state_q == IDLE && fall)
            term_q <= term_of(baud);
         if (state_q == IDLE || sub_tick)
            div_cnt <= '0;
         else
            div_cnt <= div_cnt + 13'd1;
         if (state_q == IDLE)
            sub_cnt <= '0;
         else if (sub_tick)
            sub_cnt <= sub_cnt + 4'd1;
      end
   end

   // Mid-bit samples, bit index and LSB-first shift register.
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         samp_q  <= '0;
         bit_idx <= '0;
         shift_q <= '0;
`ifdef UART_RECV_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         if (sub_tick && sub_cnt == 4'd7)
            samp_q[0] <= rx_s;
         if (sub_tick && sub_cnt == 4'd8)
            samp_q[1] <= rx_s;
         if (state_q == START && bit_end)
            bit_idx <= '0;
         else if (state_q == DATA && bit_end)
            bit_idx <= bit_idx + 3'd1;
         if (state_q == DATA && mid_tick)
            shift_q <= {vote, shift_q[7:1]};
`ifdef UART_RECV_PARITY_EN
         if (state_q == PARITY && mid_tick)
            par_q <= vote;
`endif
      end
   end

   // FSM state register.
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // FSM next-state and frame-outcome decode.
   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RECV_PARITY_EN
      perr_d  = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (fall)
               state_d = START;
         end
         START: begin
            if (mid_tick && vote)
               state_d = IDLE;
            else if (bit_end)
               state_d = DATA;
         end
         DATA: begin
            if (bit_end && bit_idx == 3'd7)
`ifdef UART_RECV_PARITY_EN
               state_d = PARITY;
`else
               state_d = STOP;
`endif
         end
`ifdef UART_RECV_PARITY_EN
         PARITY: begin
            if (bit_end)
               state_d = STOP;
         end
`endif
         STOP: begin
            if (mid_tick) begin
               state_d = IDLE;
               ferr_d  = ~vote;
`ifdef UART_RECV_PARITY_EN
               perr_d  = ^{shift_q, par_q};
               done_d  = vote & ~perr_d;
`else
               done_d  = vote;
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Registered outputs: strobes, busy flag and received byte.
   always_ff @(posedge clk_50mhz or posedge rst) begin
      if (rst) begin
         rx_data    <= 8'h00;
         rx_done    <= 1'b0;
         rx_state   <= 1'b0;
         frame_err  <= 1'b0;
`ifdef UART_RECV_PARITY_EN
         parity_err <= 1'b0;
`endif
      end else begin
         rx_done    <= done_d;
         frame_err  <= ferr_d;
         rx_state   <= (state_d != IDLE);
`ifdef UART_RECV_PARITY_EN
         parity_err <= perr_d;
`endif
         if (done_d)
            rx_data <= shift_q;
      end
   end

endmodule

// File: tb/tb_uart_recv.sv
// tb_uart_recv: self-checking bench for uart_recv (table-driven frames,
// false-start timing table, hand-written corner sequences, random frames).
module tb_uart_recv;

   logic       clk_50mhz = 1'b0;
   logic       rst;
   logic [2:0] baud;
   logic       rx_line;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rx_state;
   logic       frame_err;
`ifdef UART_RECV_PARITY_EN
   logic       parity_err;
`endif

   uart_recv #(.SYNC_STAGES(2)) dut (
      .clk_50mhz (clk_50mhz),
      .rst       (rst),
      .baud      (baud),
      .rx_line   (rx_line),
      .rx_data   (rx_data),
      .rx_done   (rx_done),
      .rx_state  (rx_state),
`ifdef UART_RECV_PARITY_EN
      .parity_err(parity_err),
`endif
      .frame_err (frame_err)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   int checks = 0;
   int fails  = 0;

   // Pulse monitor: counts strobes and flags any strobe wider than one cycle.
   int   done_cnt  = 0;
   int   ferr_cnt  = 0;
   int   wide_cnt  = 0;
   logic prev_done = 1'b0;
   logic prev_ferr = 1'b0;
   logic [7:0] last_got = 8'h00;

   always @(negedge clk_50mhz) begin
      if (rx_done) begin
         done_cnt++;
         last_got = rx_data;
      end
      if (frame_err) ferr_cnt++;
      if ((rx_done && prev_done) || (frame_err && prev_ferr)) wide_cnt++;
      prev_done = rx_done;
      prev_ferr = frame_err;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: nominal line bit period in clocks for a baud code.
   function automatic int bit_clks_of(input logic [2:0] code);
      int rate;
      case (code)
         3'd0: rate = 9600;
         3'd1: rate = 19200;
         3'd2: rate = 38400;
         3'd3: rate = 57600;
         3'd4: rate = 115200;
         default: rate = 9600;
      endcase
      return 50_000_000 / rate;
   endfunction

   task automatic drive(input logic v, input int n);
      rx_line = v;
      repeat (n) @(posedge clk_50mhz);
   endtask

   // Sends one frame; optionally changes the DUT baud code at a data bit.
   task automatic send_frame(input logic [7:0] b, input int bc, input logic stop_val,
                             input int switch_bit, input logic [2:0] switch_code);
      drive(1'b0, bc);
      for (int i = 0; i < 8; i++) begin
         if (i == switch_bit) baud = switch_code;
         drive(b[i], bc);
      end
`ifdef UART_RECV_PARITY_EN
      drive(^b, bc);
`endif
      drive(stop_val, bc);
      rx_line = 1'b1;
   endtask

   task automatic check_frame(input string name, input int d0, input int f0,
                              input int exp_done, input int exp_ferr, input logic [7:0] exp_data);
      @(negedge clk_50mhz);
      check({name, ".done"},  done_cnt - d0, exp_done);
      check({name, ".ferr"},  ferr_cnt - f0, exp_ferr);
      check({name, ".data"},  rx_data, exp_data);
      check({name, ".state"}, rx_state, 1'b0);
   endtask

   typedef struct {
      logic [2:0] code;
      logic [7:0] data;
      logic       stop_val;
      int         idle_after;
      int         exp_done;
      int         exp_ferr;
      logic [7:0] exp_data;
   } frame_vec_t;

   typedef struct {
      logic [2:0] code;
      int         rel_clks;
   } glitch_vec_t;

   frame_vec_t  fvec[5];
   glitch_vec_t gvec[6];

   initial begin
      int d0, f0;
      logic [7:0] pb;
      logic [7:0] model_data;

      // Frames back to back unless idle_after is set; A3 then 00 with no gap.
      fvec[0] = '{3'd4, 8'h55, 1'b1, 0,   1, 0, 8'h55};
      fvec[1] = '{3'd4, 8'h81, 1'b0, 434, 0, 1, 8'h55};
      fvec[2] = '{3'd4, 8'h7E, 1'b1, 0,   1, 0, 8'h7E};
      fvec[3] = '{3'd4, 8'hA3, 1'b1, 0,   1, 0, 8'hA3};
      fvec[4] = '{3'd4, 8'h00, 1'b1, 0,   1, 0, 8'h00};
      // False start returns to idle 10 sub-tick periods after the edge.
      gvec[0] = '{3'd0, 3260};
      gvec[1] = '{3'd1, 1630};
      gvec[2] = '{3'd2, 810};
      gvec[3] = '{3'd3, 540};
      gvec[4] = '{3'd7, 3260};
      gvec[5] = '{3'd4, 270};

      rst = 1'b1;
      baud = 3'd4;
      rx_line = 1'b1;
      repeat (3) @(posedge clk_50mhz);
      @(negedge clk_50mhz);
      check("reset.rx_data", rx_data, 8'h00);
      check("reset.rx_done", rx_done, 1'b0);
      check("reset.rx_state", rx_state, 1'b0);
      check("reset.frame_err", frame_err, 1'b0);
      rst = 1'b0;
      repeat (20) @(posedge clk_50mhz);

      for (int i = 0; i < 5; i++) begin
         d0 = done_cnt;
         f0 = ferr_cnt;
         baud = fvec[i].code;
         send_frame(fvec[i].data, bit_clks_of(fvec[i].code), fvec[i].stop_val, -1, 3'd0);
         repeat (fvec[i].idle_after) @(posedge clk_50mhz);
         check_frame($sformatf("frame%0d", i), d0, f0, fvec[i].exp_done, fvec[i].exp_ferr, fvec[i].exp_data);
      end
      check("b2b.first_byte_seen", last_got, 8'h00);

      d0 = done_cnt;
      f0 = ferr_cnt;
      for (int i = 0; i < 6; i++) begin
         baud = gvec[i].code;
         repeat (20) @(posedge clk_50mhz);
         drive(1'b0, 150);
         drive(1'b1, gvec[i].rel_clks * 9 / 10 - 150);
         @(negedge clk_50mhz);
         check($sformatf("glitch%0d.busy", i), rx_state, 1'b1);
         repeat (gvec[i].rel_clks * 2 / 10 + 10) @(posedge clk_50mhz);
         @(negedge clk_50mhz);
         check($sformatf("glitch%0d.idle", i), rx_state, 1'b0);
      end
      check("glitch.done", done_cnt - d0, 0);
      check("glitch.ferr", ferr_cnt - f0, 0);

      d0 = done_cnt;
      f0 = ferr_cnt;
      send_frame(8'h3C, 434, 1'b1, -1, 3'd0);
      check_frame("after_glitch", d0, f0, 1, 0, 8'h3C);

      // A 20-clock spike over the middle vote sample of data bit 2 of 0xF0.
      baud = 3'd3;
      d0 = done_cnt;
      f0 = ferr_cnt;
      pb = 8'hF0;
      drive(1'b0, 868);
      drive(pb[0], 868);
      drive(pb[1], 868);
      drive(pb[2], 465);
      drive(~pb[2], 20);
      drive(pb[2], 868 - 485);
      for (int i = 3; i < 8; i++) drive(pb[i], 868);
`ifdef UART_RECV_PARITY_EN
      drive(^pb, 868);
`endif
      drive(1'b1, 868);
      check_frame("spike", d0, f0, 1, 0, 8'hF0);

      // Baud code captured at the start edge; a mid-frame change is ignored.
      baud = 3'd4;
      d0 = done_cnt;
      f0 = ferr_cnt;
      send_frame(8'h96, 434, 1'b1, 0, 3'd0);
      check_frame("baud_hold", d0, f0, 1, 0, 8'h96);
      baud = 3'd4;

      // Asynchronous reset during data bit 4 aborts the frame.
      d0 = done_cnt;
      f0 = ferr_cnt;
      pb = 8'h5A;
      drive(1'b0, 434);
      for (int i = 0; i < 4; i++) drive(pb[i], 434);
      drive(pb[4], 200);
      rst = 1'b1;
      rx_line = 1'b1;
      #2;
      check("midreset.rx_data", rx_data, 8'h00);
      check("midreset.rx_state", rx_state, 1'b0);
      repeat (3) @(posedge clk_50mhz);
      rst = 1'b0;
      repeat (868) @(posedge clk_50mhz);
      @(negedge clk_50mhz);
      check("midreset.idle", rx_state, 1'b0);
      check("midreset.done", done_cnt - d0, 0);
      check("midreset.ferr", ferr_cnt - f0, 0);
      d0 = done_cnt;
      f0 = ferr_cnt;
      send_frame(8'h5A, 434, 1'b1, -1, 3'd0);
      check_frame("after_reset", d0, f0, 1, 0, 8'h5A);

      // Random frames against the reference model.
      model_data = 8'h5A;
      for (int i = 0; i < 3; i++) begin
         logic [7:0] b;
         logic       sv;
         b  = 8'($urandom_range(0, 255));
         sv = ($urandom_range(0, 3) != 0);
         d0 = done_cnt;
         f0 = ferr_cnt;
         send_frame(b, bit_clks_of(3'd4), sv, -1, 3'd0);
         if (!sv) repeat (434) @(posedge clk_50mhz);
         if (sv) model_data = b;
         check_frame($sformatf("rand%0d", i), d0, f0, sv ? 1 : 0, sv ? 0 : 1, model_data);
      end

      check("strobe_width", wide_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
